// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, ALU operation codes and the
// EX/MEM register layout.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 3;

  localparam logic [CTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [CTRL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [CTRL_W-1:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic [DATA_W-1:0] target;
    logic              zero;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  dst;
    logic              branch;
    logic              memwrite;
    logic              memread;
    logic              memtoreg;
    logic              regwrite;
  } exmem_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational execute-stage ALU with a zero flag for branch resolution.
module ex_alu
  import pipe_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;

  assign a_s = a_i;
  assign b_s = b_i;

  always_comb begin
    result_o = '0;
    case (ctrl_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_SLT: result_o = (a_s < b_s) ? 32'd1 : 32'd0;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// MIPS execute stage: operand forwarding from EX/MEM and MEM/WB, ALU, branch
// target adder and the EX/MEM pipeline register.
module ex_mem_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_rd1,
  input  logic [DATA_W-1:0] in_rd2,
  input  logic [DATA_W-1:0] in_imm32,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_alusrc,
  input  logic [CTRL_W-1:0] in_aluctrl,
  input  logic              in_regdst,
  input  logic              in_branch,
  input  logic              in_memwrite,
  input  logic              in_memread,
  input  logic              in_memtoreg,
  input  logic              in_regwrite,
  input  logic              wb_regwrite,
  input  logic [REG_W-1:0]  wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              write_en,
  input  logic              flush,
  output logic [DATA_W-1:0] out_target,
  output logic              out_zero,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_wdata,
  output logic [REG_W-1:0]  out_dst,
  output logic              out_branch,
  output logic              out_memwrite,
  output logic              out_memread,
  output logic              out_memtoreg,
  output logic              out_regwrite,
  output logic              out_beq_taken
);

  exmem_t            exmem_q;
  exmem_t            exmem_d;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;

  // EX/MEM takes priority over MEM/WB because it holds the younger result.
  always_comb begin
    fwd_a = in_rd1;
    if (exmem_q.regwrite && (exmem_q.dst != '0) && (exmem_q.dst == in_rs))
      fwd_a = exmem_q.alu;
    else if (wb_regwrite && (wb_dst != '0) && (wb_dst == in_rs))
      fwd_a = wb_data;
  end

  always_comb begin
    fwd_b = in_rd2;
    if (exmem_q.regwrite && (exmem_q.dst != '0) && (exmem_q.dst == in_rt))
      fwd_b = exmem_q.alu;
    else if (wb_regwrite && (wb_dst != '0) && (wb_dst == in_rt))
      fwd_b = wb_data;
  end

  assign alu_b = in_alusrc ? in_imm32 : fwd_b;

  ex_alu u_alu (
    .a_i      (fwd_a),
    .b_i      (alu_b),
    .ctrl_i   (in_aluctrl),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );

  always_comb begin
    exmem_d          = '0;
    exmem_d.target   = in_pc + (in_imm32 << 2);
    exmem_d.zero     = alu_zero;
    exmem_d.alu      = alu_res;
    exmem_d.wdata    = fwd_b;
    exmem_d.dst      = in_regdst ? in_rd : in_rt;
    exmem_d.branch   = in_branch;
    exmem_d.memwrite = in_memwrite;
    exmem_d.memread  = in_memread;
    exmem_d.memtoreg = in_memtoreg;
    exmem_d.regwrite = in_regwrite;
  end

  // EX/MEM register boundary: flush squashes, write_en low stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      exmem_q <= '0;
    else if (flush)
      exmem_q <= '0;
    else if (write_en)
      exmem_q <= exmem_d;
  end

  assign out_target    = exmem_q.target;
  assign out_zero      = exmem_q.zero;
  assign out_alu       = exmem_q.alu;
  assign out_wdata     = exmem_q.wdata;
  assign out_dst       = exmem_q.dst;
  assign out_branch    = exmem_q.branch;
  assign out_memwrite  = exmem_q.memwrite;
  assign out_memread   = exmem_q.memread;
  assign out_memtoreg  = exmem_q.memtoreg;
  assign out_regwrite  = exmem_q.regwrite;
  assign out_beq_taken = exmem_q.branch & exmem_q.zero;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed instructions push hand-computed
// register contents; a monitor compares them one cycle later.
module tb_ex_mem_stage;

  typedef struct packed {
    logic [31:0] target;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  dst;
    logic [4:0]  ctl;   // branch, memwrite, memread, memtoreg, regwrite
    logic        beq;
  } obs_t;

  typedef struct {
    int   id;
    obs_t e;
  } sb_t;

  typedef struct packed {
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        alusrc;
    logic [2:0]  aluctrl;
    logic        regdst;
    logic [4:0]  ctl;
    logic        wb_regwrite;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        write_en, flush;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] in_pc, in_rd1, in_rd2, in_imm32, wb_data;
  logic [4:0]  in_rs, in_rt, in_rd, wb_dst;
  logic        in_alusrc, in_regdst, wb_regwrite, write_en, flush;
  logic [2:0]  in_aluctrl;
  logic        in_branch, in_memwrite, in_memread, in_memtoreg, in_regwrite;
  logic [31:0] out_target, out_alu, out_wdata;
  logic        out_zero, out_branch, out_memwrite, out_memread, out_memtoreg;
  logic        out_regwrite, out_beq_taken;
  logic [4:0]  out_dst;

  int   n_tests = 0;
  int   n_fail  = 0;
  sb_t  sb[$];

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .in_pc(in_pc), .in_rd1(in_rd1), .in_rd2(in_rd2),
    .in_imm32(in_imm32), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_alusrc(in_alusrc), .in_aluctrl(in_aluctrl), .in_regdst(in_regdst),
    .in_branch(in_branch), .in_memwrite(in_memwrite), .in_memread(in_memread),
    .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite),
    .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_data(wb_data),
    .write_en(write_en), .flush(flush), .out_target(out_target),
    .out_zero(out_zero), .out_alu(out_alu), .out_wdata(out_wdata),
    .out_dst(out_dst), .out_branch(out_branch), .out_memwrite(out_memwrite),
    .out_memread(out_memread), .out_memtoreg(out_memtoreg),
    .out_regwrite(out_regwrite), .out_beq_taken(out_beq_taken)
  );

  function automatic obs_t observe();
    obs_t o;
    o.target = out_target;
    o.zero   = out_zero;
    o.alu    = out_alu;
    o.wdata  = out_wdata;
    o.dst    = out_dst;
    o.ctl    = {out_branch, out_memwrite, out_memread, out_memtoreg, out_regwrite};
    o.beq    = out_beq_taken;
    return o;
  endfunction

  task automatic check(input int id, input obs_t e);
    obs_t g;
    g = observe();
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL case%0d: got alu=%h tgt=%h wd=%h dst=%0d ctl=%b z=%b beq=%b, want alu=%h tgt=%h wd=%h dst=%0d ctl=%b z=%b beq=%b",
               id, g.alu, g.target, g.wdata, g.dst, g.ctl, g.zero, g.beq,
               e.alu, e.target, e.wdata, e.dst, e.ctl, e.zero, e.beq);
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    s.write_en = 1'b1;
    return s;
  endfunction

  function automatic obs_t ex(input logic [31:0] alu, input logic [31:0] tgt,
                              input logic [31:0] wd, input logic [4:0] dst,
                              input logic [4:0] ctl, input logic z);
    obs_t o;
    o.target = tgt; o.alu = alu; o.wdata = wd; o.dst = dst;
    o.ctl = ctl; o.zero = z; o.beq = ctl[4] & z;
    return o;
  endfunction

  task automatic apply(input stim_t s);
    in_pc = s.pc; in_rd1 = s.rd1; in_rd2 = s.rd2; in_imm32 = s.imm;
    in_rs = s.rs; in_rt = s.rt; in_rd = s.rd;
    in_alusrc = s.alusrc; in_aluctrl = s.aluctrl; in_regdst = s.regdst;
    {in_branch, in_memwrite, in_memread, in_memtoreg, in_regwrite} = s.ctl;
    wb_regwrite = s.wb_regwrite; wb_dst = s.wb_dst; wb_data = s.wb_data;
    write_en = s.write_en; flush = s.flush;
  endtask

  // Apply one ID/EX word just after an edge; its result is due at the next edge.
  task automatic step(input int id, input stim_t s, input obs_t e);
    sb_t t;
    @(posedge clk);
    #2;
    apply(s);
    t.id = id;
    t.e  = e;
    sb.push_back(t);
  endtask

  initial begin : monitor
    sb_t t;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        t = sb.pop_front();
        check(t.id, t.e);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    obs_t  zero_o, held;
    zero_o = '0;

    s = nop();
    s.rd1 = 32'hDEAD_BEEF; s.rd2 = 32'h1234_5678; s.pc = 32'h40;
    s.ctl = 5'b11111; s.aluctrl = 3'b010; s.rs = 5'd3; s.rt = 5'd4;
    apply(s);
    #1 rst = 1'b1;
    #2 check(0, zero_o);
    @(posedge clk); #1 check(1, zero_o);
    @(negedge clk) rst = 1'b0;

    s = nop(); s.aluctrl = 3'b010; s.rd1 = 5; s.rd2 = 7; s.rs = 1; s.rt = 2;
    s.regdst = 1; s.rd = 3; s.ctl = 5'b00001;
    step(2, s, ex(32'd12, 32'd0, 32'd7, 5'd3, 5'b00001, 1'b0));

    s = nop(); s.aluctrl = 3'b010; s.rd1 = 60; s.rd2 = 40; s.rs = 5; s.rt = 6;
    s.regdst = 1; s.rd = 4; s.ctl = 5'b00001;
    step(3, s, ex(32'd100, 32'd0, 32'd40, 5'd4, 5'b00001, 1'b0));

    s = nop(); s.aluctrl = 3'b010; s.rd1 = 1; s.rd2 = 2; s.rs = 4; s.rt = 4;
    s.wb_regwrite = 1; s.wb_dst = 4; s.wb_data = 55;
    s.regdst = 1; s.rd = 0; s.ctl = 5'b00001;
    step(4, s, ex(32'd200, 32'd0, 32'd100, 5'd0, 5'b00001, 1'b0));

    s = nop(); s.aluctrl = 3'b010; s.rd1 = 11; s.rd2 = 22; s.rs = 0; s.rt = 0;
    s.wb_regwrite = 1; s.wb_dst = 0; s.wb_data = 999;
    step(5, s, ex(32'd33, 32'd0, 32'd22, 5'd0, 5'b00000, 1'b0));

    s = nop(); s.aluctrl = 3'b010; s.rd1 = 3; s.rd2 = 4; s.rs = 9; s.rt = 10;
    s.wb_regwrite = 1; s.wb_dst = 10; s.wb_data = 50;
    step(6, s, ex(32'd53, 32'd0, 32'd50, 5'd10, 5'b00000, 1'b0));

    s = nop(); s.aluctrl = 3'b110; s.rd1 = 9; s.rd2 = 9; s.rs = 1; s.rt = 2;
    s.pc = 32'h100; s.imm = 32'hFFFF_FFFF; s.ctl = 5'b10000;
    step(7, s, ex(32'd0, 32'hFC, 32'd9, 5'd2, 5'b10000, 1'b1));

    s = nop(); s.aluctrl = 3'b111; s.rd1 = 32'hFFFF_FFFF; s.rd2 = 1; s.rs = 1; s.rt = 2;
    step(8, s, ex(32'd1, 32'd0, 32'd1, 5'd2, 5'b00000, 1'b0));

    s.rd1 = 1; s.rd2 = 32'hFFFF_FFFF;
    step(9, s, ex(32'd0, 32'd0, 32'hFFFF_FFFF, 5'd2, 5'b00000, 1'b1));

    s = nop(); s.aluctrl = 3'b011; s.rd1 = 5; s.rd2 = 3; s.rs = 1; s.rt = 2;
    step(10, s, ex(32'd0, 32'd0, 32'd3, 5'd2, 5'b00000, 1'b1));

    s = nop(); s.aluctrl = 3'b001; s.rd1 = 32'hF0; s.rd2 = 32'h0F; s.rs = 1; s.rt = 2;
    step(11, s, ex(32'hFF, 32'd0, 32'h0F, 5'd2, 5'b00000, 1'b0));

    s = nop(); s.aluctrl = 3'b000; s.rd1 = 32'hF0; s.rd2 = 32'h3C; s.rs = 1; s.rt = 2;
    s.regdst = 1; s.rd = 8; s.ctl = 5'b00001;
    held = ex(32'h30, 32'd0, 32'h3C, 5'd8, 5'b00001, 1'b0);
    step(12, s, held);

    s = nop(); s.write_en = 0; s.aluctrl = 3'b010; s.rd1 = 1234; s.rs = 8;
    s.ctl = 5'b11111; s.pc = 32'h500;
    step(13, s, held);
    s.rd2 = 77; s.flush = 0;
    step(14, s, held);

    s = nop(); s.aluctrl = 3'b010; s.rd1 = 0; s.rd2 = 5; s.rs = 8; s.rt = 3;
    step(15, s, ex(32'h35, 32'd0, 32'd5, 5'd3, 5'b00000, 1'b0));

    s = nop(); s.flush = 1; s.aluctrl = 3'b010; s.rd1 = 6; s.rd2 = 6;
    s.ctl = 5'b11111; s.pc = 32'h80; s.regdst = 1; s.rd = 9;
    step(16, s, zero_o);

    s = nop(); s.aluctrl = 3'b010; s.alusrc = 1; s.imm = 8; s.rd1 = 32'h1000;
    s.rs = 1; s.rt = 5; s.wb_regwrite = 1; s.wb_dst = 5; s.wb_data = 32'hABCD;
    s.ctl = 5'b01000;
    step(17, s, ex(32'h1008, 32'h20, 32'hABCD, 5'd5, 5'b01000, 1'b0));

    s = nop();
    step(18, s, ex(32'd0, 32'd0, 32'd0, 5'd0, 5'b00000, 1'b1));

    s = nop(); s.aluctrl = 3'b010; s.rd1 = 5; s.rd2 = 7; s.rs = 1; s.rt = 2;
    s.regdst = 1; s.rd = 3; s.ctl = 5'b00111; s.pc = 4; s.imm = 1;
    step(19, s, ex(32'd12, 32'd8, 32'd7, 5'd3, 5'b00111, 1'b0));

    @(posedge clk);
    #4 rst = 1'b1;
    #1 check(20, zero_o);
    @(negedge clk) rst = 1'b0;

    s = nop(); s.aluctrl = 3'b110; s.rd1 = 20; s.rd2 = 8; s.rs = 1; s.rt = 2;
    s.ctl = 5'b00001;
    step(21, s, ex(32'd12, 32'd0, 32'd8, 5'd2, 5'b00001, 1'b0));

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage plus EX/MEM pipeline register of the 5-stage MIPS pipeline. Consumes the ID/EX register outputs, resolves data hazards by forwarding from EX/MEM and MEM/WB, and computes the ALU result, zero flag, destination register and branch target. Registers these values together with the MEM/WB control bits for the MEM stage.

## Interface
Parameters:
- none; widths fixed at 32-bit data, 5-bit register index, 3-bit ALU control.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_pc  in  32  PC+4 of the instruction in EX
- in_rd1, in_rd2  in  32  register-file read data for rs / rt
- in_imm32  in  32  sign-extended immediate
- in_rs, in_rt, in_rd  in  5  register indices
- in_alusrc  in  1  1: ALU B = in_imm32; 0: forwarded rt value
- in_aluctrl  in  3  ALU operation
- in_regdst  in  1  1: destination = in_rd; 0: in_rt
- in_branch, in_memwrite, in_memread, in_memtoreg, in_regwrite  in  1 each  control pass-through
- wb_regwrite  in  1  MEM/WB RegWrite
- wb_dst  in  5  MEM/WB destination register
- wb_data  in  32  value being written back
- write_en  in  1  1: register loads; 0: holds (stall)
- flush  in  1  synchronous squash of the register (taken branch)
- out_target  out  32  in_pc + (in_imm32 << 2), registered
- out_zero  out  1  ALU result == 0, registered
- out_alu  out  32  ALU result, registered
- out_wdata  out  32  forwarded rt value (store data), registered
- out_dst  out  5  destination register, registered
- out_branch, out_memwrite, out_memread, out_memtoreg, out_regwrite  out  1 each  registered control
- out_beq_taken  out  1  out_branch & out_zero (combinational from registers)

## Operation
- ALU codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed, result 32'd1 or 32'd0); all other codes give 32'd0.
- ADD/SUB and the target add wrap modulo 2^32; no overflow detection.
- Forward A (rs) priority:
  - out_regwrite && out_dst != 0 && out_dst == in_rs → out_alu;
  - else wb_regwrite && wb_dst != 0 && wb_dst == in_rs → wb_data;
  - else in_rd1.
- Forward B is identical, using in_rt and in_rd2.
- Register 0 is never forwarded.
- A load-use pair is never seen back-to-back; the upstream hazard logic inserts a bubble. The EX/MEM source is used even when out_memread = 1.
- ALU A = forward A; ALU B = in_alusrc ? in_imm32 : forward B; out_wdata takes forward B regardless of in_alusrc.
- An all-zero ID/EX bubble (aluctrl 000, all control bits 0) passes through as an all-zero control bubble.

## Timing
- Reset (asynchronous): every registered output is 0, so out_beq_taken = 0.
- Per rising edge, priority is:
  - flush = 1: all outputs cleared to 0;
  - else write_en = 1: load the new values;
  - else hold all values.
- flush overrides write_en.
- Latency: 1 cycle from ID/EX outputs to out_*. Forwarding and the ALU are combinational within the cycle.
- While held, forwarding from EX/MEM uses the held values.
- rst asserted mid-operation clears the outputs immediately, without waiting for clk.
- Deasserting rst takes effect at the next edge.

## Structure
- Shared package pipe_pkg holds the ALU code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT) and the data/register-index width constants.
- Sub-module ex_alu is purely combinational: operands a and b, ctrl, result, zero.
- Forwarding muxes and the EX/MEM register live in ex_mem_stage.

## Test plan
- Reset: rst = 1 with arbitrary inputs → all out_* = 0; release rst; in_aluctrl = 010, rd1 = 5, rd2 = 7, alusrc = 0, regwrite = 1, regdst = 1, rd = 3 → next edge: out_alu = 12, out_dst = 3, out_zero = 0.
- Forwarding priority: EX/MEM holds dst = 4, alu = 100; wb_dst = 4, wb_data = 55; next instruction has rs = 4, rd1 = 1, rt = 4, alusrc = 0, ADD → out_alu = 200. Repeat with out_dst = 0 and rs = rt = 0 → operands come from rd1/rd2.
- SUB/BEQ: rd1 = rd2 = 9, aluctrl = 110, branch = 1, pc = 0x100, imm = 0xFFFFFFFF → out_zero = 1, out_target = 0xFC, out_beq_taken = 1.
- SLT signed: rd1 = 0xFFFFFFFF, rd2 = 1 → out_alu = 1. Swap the operands → out_alu = 0. aluctrl = 011 → out_alu = 0.
- Stall/flush: write_en = 0 for 2 cycles → outputs unchanged. flush = 1 together with write_en = 1 → all outputs 0 at the next edge.
- Store: alusrc = 1, imm = 8, rd1 = 0x1000, memwrite = 1, rt forwarded from wb_data = 0xABCD → out_alu = 0x1008, out_wdata = 0xABCD.
